// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD host front end.
package gcd_pkg;

  localparam int unsigned DefaultWidth   = 16;
  localparam int unsigned DefaultTimeout = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StLdA,
    StLdB,
    StWait,
    StResp
  } gcd_state_e;

endpackage

// File: rtl/gcd_host_timer.sv
// Watchdog for the WAIT state: counts enabled cycles and flags the last allowed one.
module gcd_host_timer
  import gcd_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Fires in the TIMEOUT-th enabled cycle so the host leaves WAIT after exactly TIMEOUT cycles.
  assign expired = en && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_host.sv
// Request/response front end sequencing operand pairs into an external subtraction GCD core.
// Define GCD_HOST_TIMEOUT_EN to add a WAIT-state watchdog that reports rsp_err on expiry.
module gcd_host
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             busy
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, gcd_q;
  logic             wait_first_q;
  logic             req_hs, bypass, done_ok, expired;

  assign req_hs  = req_valid && req_ready;
  assign bypass  = (req_a == '0) || (req_b == '0);
  // A done still high from the previous run is visible in the first WAIT cycle only.
  assign done_ok = (state_q == StWait) && core_done && !wait_first_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_hs) state_d = bypass ? StResp : StStart;
      StStart: state_d = StLdA;
      StLdA:   state_d = StLdB;
      StLdB:   state_d = StWait;
      StWait:  if (done_ok || expired) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    core_start = 1'b0;
    core_data  = '0;
    busy       = 1'b1;
    unique case (state_q)
      StIdle: begin
        req_ready = rst_n;
        busy      = 1'b0;
      end
      StStart: core_start = 1'b1;
      StLdA:   core_data  = a_q;
      StLdB:   core_data  = b_q;
      StResp:  rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      gcd_q        <= '0;
      wait_first_q <= 1'b0;
    end else begin
      wait_first_q <= (state_q == StLdB);
      if (req_hs) begin
        a_q <= req_a;
        b_q <= req_b;
        if (bypass) gcd_q <= req_a | req_b;
      end
      if (done_ok) begin
        gcd_q <= core_result;
      end else if (expired) begin
        gcd_q <= '0;
      end
    end
  end

  assign rsp_gcd = gcd_q;

`ifdef GCD_HOST_TIMEOUT_EN
  logic err_q;

  gcd_host_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == StLdB),
    .en     (state_q == StWait),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (req_hs || done_ok) begin
      err_q <= 1'b0;
    end else if (expired) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  // TIMEOUT only sizes the watchdog, which this build omits.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
  assign rsp_err        = 1'b0;
`endif

endmodule
